// File: rtl/map_bram_arbiter.sv
// map_bram_arbiter
//   Shares one registered-read BRAM between C_NUM_REQ mapper lanes using a
//   round-robin pointer, and forwards a single loader write stream to the
//   BRAM write port. A lane whose address matches the write being accepted
//   this cycle is skipped so it can never return pre-write data.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req, i_req_addr    per-lane read request / packed lane addresses
//   o_gnt                one-hot grant (combinational)
//   o_rsp_valid/_id/_data  response two cycles after grant, no backpressure
//   i_wr_en/_addr/_data  loader write, o_wr_ready accepts it
//   o_bram_wen/_waddr/_wdata  registered BRAM write port
//   o_bram_ce/_raddr     registered BRAM read port
//   i_bram_rdata         BRAM read data

// Per-lane eligibility: requesting and not colliding with the write
// being accepted in the same cycle.
module map_bram_arb_lane #(
   parameter int C_LOG_DEPTH = 2
) (
   input  logic                   i_req,
   input  logic [C_LOG_DEPTH-1:0] i_addr,
   input  logic                   i_wr_acc,
   input  logic [C_LOG_DEPTH-1:0] i_wr_addr,
   output logic                   o_elig
);
   assign o_elig = i_req & ~(i_wr_acc & (i_addr == i_wr_addr));
endmodule

module map_bram_arbiter #(
   parameter int C_WIDTH     = 32,
   parameter int C_LOG_DEPTH = 2,
   parameter int C_NUM_REQ   = 4,
   parameter int C_LOG_REQ   = 2
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic [C_NUM_REQ-1:0]             i_req,
   input  logic [C_NUM_REQ*C_LOG_DEPTH-1:0] i_req_addr,
   output logic [C_NUM_REQ-1:0]             o_gnt,
   output logic [C_NUM_REQ-1:0]             o_rsp_valid,
   output logic [C_LOG_REQ-1:0]             o_rsp_id,
   output logic [C_WIDTH-1:0]               o_rsp_data,
   input  logic                             i_wr_en,
   input  logic [C_LOG_DEPTH-1:0]           i_wr_addr,
   input  logic [C_WIDTH-1:0]               i_wr_data,
   output logic                             o_wr_ready,
   output logic                             o_bram_wen,
   output logic [C_LOG_DEPTH-1:0]           o_bram_waddr,
   output logic [C_WIDTH-1:0]               o_bram_wdata,
   output logic                             o_bram_ce,
   output logic [C_LOG_DEPTH-1:0]           o_bram_raddr,
   input  logic [C_WIDTH-1:0]               i_bram_rdata
);

   logic                   wr_acc;
   logic [C_NUM_REQ-1:0]   elig;
   logic                   gnt_vld;
   logic [C_LOG_REQ-1:0]   gnt_idx;
   logic [C_LOG_DEPTH-1:0] gnt_addr;
   logic [C_NUM_REQ-1:0]   gnt_oh;
   int                     pick_d;
   int                     best_d;

   logic [C_LOG_REQ-1:0]   r_last_q, r_last_d;
   logic                   ce_q, ce_d;
   logic [C_LOG_DEPTH-1:0] raddr_q, raddr_d;
   logic                   iss_vld_q, iss_vld_d;
   logic [C_LOG_REQ-1:0]   iss_id_q, iss_id_d;
   logic [C_NUM_REQ-1:0]   rsp_vld_q, rsp_vld_d;
   logic [C_LOG_REQ-1:0]   rsp_id_q, rsp_id_d;
   logic                   wen_q, wen_d;
   logic [C_LOG_DEPTH-1:0] waddr_q, waddr_d;
   logic [C_WIDTH-1:0]     wdata_q, wdata_d;

   // Writes are never stalled outside reset.
   assign o_wr_ready = ~i_rst;
   assign wr_acc     = i_wr_en & o_wr_ready;

   for (genvar k = 0; k < C_NUM_REQ; k++) begin : g_lane
      map_bram_arb_lane #(.C_LOG_DEPTH(C_LOG_DEPTH)) u_lane (
         .i_req    (i_req[k]),
         .i_addr   (i_req_addr[k*C_LOG_DEPTH +: C_LOG_DEPTH]),
         .i_wr_acc (wr_acc),
         .i_wr_addr(i_wr_addr),
         .o_elig   (elig[k])
      );
   end

   // Round-robin pick: each lane's distance from r_last+1 (mod C_NUM_REQ)
   // is its priority; smallest distance among eligible lanes wins. Works for
   // non-power-of-2 lane counts since the wrap is a true modulo.
   always_comb begin : p_pick
      gnt_idx  = '0;
      gnt_addr = '0;
      gnt_oh   = '0;
      pick_d   = 0;
      best_d   = C_NUM_REQ;
      for (int k = 0; k < C_NUM_REQ; k++) begin
         pick_d = (k + C_NUM_REQ - int'(r_last_q) - 1) % C_NUM_REQ;
         if (elig[k] && pick_d < best_d) begin
            best_d   = pick_d;
            gnt_idx  = C_LOG_REQ'(k);
            gnt_addr = i_req_addr[k*C_LOG_DEPTH +: C_LOG_DEPTH];
         end
      end
      gnt_vld = (best_d < C_NUM_REQ) && !i_rst;
      for (int k = 0; k < C_NUM_REQ; k++)
         gnt_oh[k] = gnt_vld && (gnt_idx == C_LOG_REQ'(k));
   end

   assign o_gnt = gnt_oh;

   always_comb begin : p_next
      r_last_d  = r_last_q;
      ce_d      = gnt_vld;
      raddr_d   = raddr_q;
      iss_vld_d = gnt_vld;
      iss_id_d  = gnt_vld ? gnt_idx : iss_id_q;
      rsp_id_d  = iss_vld_q ? iss_id_q : rsp_id_q;
      wen_d     = wr_acc;
      waddr_d   = wr_acc ? i_wr_addr : waddr_q;
      wdata_d   = wr_acc ? i_wr_data : wdata_q;
      rsp_vld_d = '0;
      for (int k = 0; k < C_NUM_REQ; k++)
         rsp_vld_d[k] = iss_vld_q && (iss_id_q == C_LOG_REQ'(k));
      if (gnt_vld) begin
         r_last_d = gnt_idx;
         raddr_d  = gnt_addr;
      end
   end

   // Reset clears the issue stage, so reads in flight are dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_q  <= C_LOG_REQ'(C_NUM_REQ-1);
         ce_q      <= 1'b0;
         raddr_q   <= '0;
         iss_vld_q <= 1'b0;
         iss_id_q  <= '0;
         rsp_vld_q <= '0;
         rsp_id_q  <= '0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         r_last_q  <= r_last_d;
         ce_q      <= ce_d;
         raddr_q   <= raddr_d;
         iss_vld_q <= iss_vld_d;
         iss_id_q  <= iss_id_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_id_q  <= rsp_id_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign o_bram_ce    = ce_q;
   assign o_bram_raddr = raddr_q;
   assign o_bram_wen   = wen_q;
   assign o_bram_waddr = waddr_q;
   assign o_bram_wdata = wdata_q;
   assign o_rsp_valid  = rsp_vld_q;
   assign o_rsp_id     = rsp_id_q;
   assign o_rsp_data   = i_bram_rdata;

endmodule

// File: doc/map_bram_arbiter.md
# map_bram_arbiter

Round-robin arbiter that shares one `bram_mapper` instance among `C_NUM_REQ` mapper lanes. It multiplexes lane read requests onto the BRAM's single registered read port and routes each returned word back to its lane with a one-hot valid. It also forwards a single loader write stream to the BRAM write port. It sits between the mapper lanes and the BRAM, driving every BRAM input and consuming `o_rdata`.

## Interface
- `C_WIDTH`, 32: data word width; must match the BRAM.
- `C_LOG_DEPTH`, 2: BRAM address width.
- `C_NUM_REQ`, 4: number of read requesters; 2..16.
- `C_LOG_REQ`, 2: clog2(`C_NUM_REQ`).

- `i_clk` in 1: single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_req` in `C_NUM_REQ`: per-lane read request; held until granted.
- `i_req_addr` in `C_NUM_REQ*C_LOG_DEPTH`: lane k address at bits [k*C_LOG_DEPTH +: C_LOG_DEPTH].
- `o_gnt` out `C_NUM_REQ`: one-hot or zero, combinational; the read transfers when `i_req[k]` and `o_gnt[k]` are both high.
- `o_rsp_valid` out `C_NUM_REQ`: one-hot, registered; read data valid for that lane.
- `o_rsp_id` out `C_LOG_REQ`: index of the lane receiving the response.
- `o_rsp_data` out `C_WIDTH`: read word, wired directly from `i_bram_rdata`.
- `i_wr_en` in 1: loader write request.
- `i_wr_addr` in `C_LOG_DEPTH`, `i_wr_data` in `C_WIDTH`: loader write address and data.
- `o_wr_ready` out 1: write accepted when `i_wr_en` and `o_wr_ready` are both high.
- `o_bram_wen` out 1, `o_bram_waddr` out `C_LOG_DEPTH`, `o_bram_wdata` out `C_WIDTH`: to the BRAM write port; registered.
- `o_bram_ce` out 1, `o_bram_raddr` out `C_LOG_DEPTH`: to the BRAM read port; registered.
- `i_bram_rdata` in `C_WIDTH`: BRAM `o_rdata`.

## Operation
- **Arbitration pointer.** `r_last` (`C_LOG_REQ` bits) holds the last granted lane. The search order is `r_last+1`, `r_last+2`, … modulo `C_NUM_REQ`. The first eligible lane is granted. On a grant, `r_last` updates to the granted index.
- **Eligibility.** Lane k is eligible when `i_req[k]` is high and there is no write conflict.
- **Write conflict.** A conflict exists when `i_wr_en` && `o_wr_ready` && lane k's address == `i_wr_addr`. The lane is skipped this cycle and stays pending. Remaining lanes still arbitrate.
- **Write path.**
  - `o_wr_ready` is 0 during reset and 1 otherwise; writes are never stalled.
  - An accepted write registers into `o_bram_wen`/`waddr`/`wdata` for exactly one cycle.
- **Read issue.**
  - A grant in cycle T registers `o_bram_ce=1` and `o_bram_raddr` = the granted address, visible in T+1.
  - It also registers the granted index into an issue stage (`r_iss_vld`, `r_iss_id`).
  - Without a grant, `o_bram_ce=0` and `o_bram_raddr` holds its value.
- **Response.** The issue stage advances one cycle. In T+2, `o_rsp_valid[id]=1`, `o_rsp_id=id`, and `o_rsp_data` = the BRAM word.
- **Stall-free.** Lanes must accept the response in the cycle it is presented; there is no backpressure.
- **Width rules.**
  - Lane address slices are fixed-width; there is no truncation.
  - Pointer wrap uses modulo `C_NUM_REQ`, correct for non-power-of-2 lane counts.
- **Reset.**
  - `o_gnt` is forced to 0 while `i_rst` is high.
  - All registered outputs and the issue stage clear to 0.
  - `r_last` is set to `C_NUM_REQ-1`, so lane 0 has first priority.
  - Reads in flight when reset asserts produce no response.
  - The BRAM contents are not touched.

## Timing
- Read latency: grant in cycle T → `o_rsp_valid` in T+2. Throughput is one read per cycle aggregate.
- A single lane holding `i_req` continuously is granted every cycle while no other lane requests.
- With all lanes requesting, each lane is granted once per `C_NUM_REQ` cycles.
- A write accepted in T reaches the BRAM in T+1. A read granted in T+1 or later returns the new data.
- A read to the same address in the same cycle as the write is deferred to T+1 by the conflict rule, so it never returns stale data.
- Reset values:
  - `o_gnt`, `o_rsp_valid`, `o_rsp_id`, `o_bram_ce`, `o_bram_wen`, `o_wr_ready` = 0.
  - `o_bram_raddr`, `o_bram_waddr`, `o_bram_wdata` = 0.
  - `o_rsp_data` follows `i_bram_rdata`.

## Test plan
- **Single lane:** after reset, lane 2 requests addr 1 (BRAM[1]=0x00100010) → `o_gnt`=0100 same cycle; `o_rsp_valid`=0100, `o_rsp_id`=2, data 0x00100010 two cycles later.
- **Fairness:** all 4 lanes request continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, each 2 cycles after its grant.
- **Write conflict:** write addr 3 ← 0xDEADBEEF in the same cycle that lane 0 requests addr 3 while lane 1 requests addr 0 →
  - lane 1 is granted that cycle;
  - lane 0 is granted the next cycle and receives 0xDEADBEEF.
- **Write then read:** write addr 2 ← 0xA5A5A5A5 in cycle T; lane 3 reads addr 2 in T+1 → 0xA5A5A5A5 returned in T+3.
- **Reset mid-operation:** lanes 0 and 1 granted in consecutive cycles; `i_rst` asserted the following cycle →
  - no `o_rsp_valid` from the cycle after reset asserts;
  - after release, lane 0 has priority again.
- **Idle:** no requests and no writes for 10 cycles → `o_bram_ce`=0, `o_bram_wen`=0, `o_rsp_valid`=0 throughout; `o_bram_raddr` holds its last value.
